// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter between CPU and loader.
package dmem_arb_pkg;

  // Arbiter FSM: no loader request, loader waiting, loader read response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    RESP = 2'd2
  } dmem_arb_state_e;

  localparam int         DMEM_ADDR_W = 14;
  localparam logic [3:0] STRB_NONE   = 4'b0000;

  // Wide enough for any MAX_WAIT in 1..255.
  localparam int         WAIT_W      = 8;

endpackage

// File: rtl/dmem_arb_wait_cnt.sv
// Saturating loader wait counter: counts cycles a loader request has been
// held off by CPU traffic, stops at MAX_WAIT and flags it.
module dmem_arb_wait_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_max
);

  localparam logic [WAIT_W-1:0] MAX_V = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] r_cnt;
  logic              w_at_max;

  assign w_at_max = (r_cnt == MAX_V);
  assign o_at_max = w_at_max;

  // Clear wins over increment; increment stops at MAX_WAIT.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: the CPU E/M stages own the RAM by default; the loader
// port is granted when the CPU is idle, or forcibly (stalling the CPU) once
// it has waited MAX_WAIT cycles. Loader reads return one cycle after grant
// on RAM port 1.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int MAX_WAIT = 8
) (
  input  logic              CLK,
  input  logic              RST,
  // CPU side
  input  logic              cpu_re1,
  input  logic              cpu_re2,
  input  logic [ADDR_W-1:0] cpu_raddr1,
  input  logic [ADDR_W-1:0] cpu_raddr2,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_stall,
  // loader / debug side
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_write,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic [3:0]        ld_wstrb,
  output logic              ld_rvalid,
  output logic [31:0]       ld_rdata,
  // RAM side
  output logic [ADDR_W-1:0] ram_raddr1,
  output logic [ADDR_W-1:0] ram_raddr2,
  input  logic [31:0]       ram_rdata1,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_wstrb
);

  dmem_arb_state_e r_state, w_state_nxt;
  logic            r_forced, w_forced_nxt;
  logic            w_busy;
  logic            w_grant;
  logic            w_cnt_clr;
  logic            w_cnt_inc;
  logic            w_at_max;

  assign w_busy = cpu_re1 | cpu_re2 | cpu_we;

  dmem_arb_wait_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_cnt (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_clr    (w_cnt_clr),
    .i_inc    (w_cnt_inc),
    .o_at_max (w_at_max)
  );

  // Next-state, grant decision and wait-counter control.
  always_comb begin
    w_state_nxt  = r_state;
    w_forced_nxt = r_forced;
    w_grant      = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      IDLE: begin
        if (ld_valid) begin
          if (!w_busy) begin
            w_grant = 1'b1;
          end else begin
            // counter is 0 in IDLE, so this starts the wait at 1
            w_state_nxt = PEND;
            w_cnt_inc   = 1'b1;
          end
        end
      end
      PEND: begin
        if (!ld_valid) begin
          w_state_nxt = IDLE;
          w_cnt_clr   = 1'b1;
        end else if (!w_busy || w_at_max) begin
          w_grant = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      RESP: begin
        // Never grant here: port 1 is carrying the previous response.
        // A follow-on request counts this cycle as its first wait cycle.
        w_state_nxt = ld_valid ? PEND : IDLE;
        w_cnt_inc   = ld_valid;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_clr   = 1'b1;
      end
    endcase
    if (w_grant) begin
      w_cnt_clr    = 1'b1;
      w_cnt_inc    = 1'b0;
      w_forced_nxt = w_busy;
      w_state_nxt  = ld_write ? IDLE : RESP;
    end
  end

  // FSM state and forced-grant flag for the RESP-cycle stall.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_forced <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_forced <= w_forced_nxt;
    end
  end

  // Output muxes: CPU drives the RAM unless the loader holds the grant;
  // everything handshake-related is quiet in reset.
  always_comb begin
    ld_ready   = 1'b0;
    ld_rvalid  = 1'b0;
    ld_rdata   = '0;
    cpu_stall  = 1'b0;
    ram_raddr1 = cpu_raddr1;
    ram_raddr2 = cpu_raddr2;
    ram_waddr  = cpu_waddr;
    ram_wdata  = cpu_wdata;
    ram_wstrb  = STRB_NONE;
    if (!RST) begin
      if (w_grant) begin
        ld_ready  = 1'b1;
        cpu_stall = w_busy;
        if (ld_write) begin
          ram_waddr = ld_addr;
          ram_wdata = ld_wdata;
          ram_wstrb = ld_wstrb;
        end else begin
          ram_raddr1 = ld_addr;
        end
      end else if (r_state == RESP) begin
        // Port-1 data belongs to the loader, so a busy CPU must hold;
        // a stalled store is simply not written.
        ld_rvalid = 1'b1;
        ld_rdata  = ram_rdata1;
        cpu_stall = r_forced | w_busy;
      end else if (cpu_we) begin
        ram_wstrb = cpu_wstrb;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then constrained-random traffic,
// every cycle compared against a cycle-level reference model and a shadow RAM.
module tb_dmem_arbiter;

  localparam int AW    = 14;
  localparam int MW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST;
  logic          cpu_re1, cpu_re2, cpu_we;
  logic [AW-1:0] cpu_raddr1, cpu_raddr2, cpu_waddr;
  logic [31:0]   cpu_wdata;
  logic [3:0]    cpu_wstrb;
  logic          cpu_stall;
  logic          ld_valid, ld_ready, ld_write;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata;
  logic [3:0]    ld_wstrb;
  logic          ld_rvalid;
  logic [31:0]   ld_rdata;
  logic [AW-1:0] ram_raddr1, ram_raddr2, ram_waddr;
  logic [31:0]   ram_rdata1, ram_wdata;
  logic [3:0]    ram_wstrb;

  dmem_arbiter #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_re1(cpu_re1), .cpu_re2(cpu_re2),
    .cpu_raddr1(cpu_raddr1), .cpu_raddr2(cpu_raddr2),
    .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_stall(cpu_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_write(ld_write), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_wstrb(ld_wstrb), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .ram_raddr1(ram_raddr1), .ram_raddr2(ram_raddr2), .ram_rdata1(ram_rdata1),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] init_val(int a);
    if (a == 32'h10) return 32'hDEADBEEF;
    if (a == 32'h20) return 32'hAAAAAAAA;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Environment RAM: registered port-1 read, byte-strobed write.
  logic [31:0] ram [0:DEPTH-1];
  bit          ram_init_done = 1'b0;
  always @(posedge CLK) begin
    if (!ram_init_done) begin
      for (int a = 0; a < DEPTH; a++) ram[a] <= init_val(a);
      ram_init_done <= 1'b1;
    end else begin
      ram_rdata1 <= ram[ram_raddr1];
      if (ram_wstrb != 4'b0000) ram[ram_waddr] <= merge(ram[ram_waddr], ram_wdata, ram_wstrb);
    end
  end

  // Reference model state
  logic [31:0]   shadow [0:DEPTH-1];
  int            m_waited;
  bit            m_resp, m_resp_forced;
  logic [31:0]   m_resp_data;
  int            n_waited;
  bit            n_resp, n_forced;
  logic [31:0]   n_data;
  logic          e_ready, e_stall, e_rvalid;
  logic [31:0]   e_rdata, e_wd;
  logic [AW-1:0] e_ra1, e_ra2, e_wa;
  logic [3:0]    e_ws;

  int total = 0;
  int bad   = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for the current inputs from the arbitration rules.
  task automatic model_eval();
    bit busy, grant;
    busy     = cpu_re1 | cpu_re2 | cpu_we;
    e_ready  = 1'b0; e_stall = 1'b0; e_rvalid = 1'b0; e_rdata = 32'h0;
    e_ra1    = cpu_raddr1; e_ra2 = cpu_raddr2;
    e_wa     = cpu_waddr; e_wd = cpu_wdata; e_ws = 4'b0000;
    n_waited = m_waited; n_resp = 1'b0; n_forced = m_resp_forced; n_data = m_resp_data;
    if (RST) begin
      n_waited = 0;
    end else if (m_resp) begin
      e_rvalid = 1'b1;
      e_rdata  = m_resp_data;
      e_stall  = m_resp_forced | busy;
      n_waited = ld_valid ? 1 : 0;
    end else begin
      grant = ld_valid && (!busy || m_waited == MW);
      if (grant) begin
        e_ready  = 1'b1;
        e_stall  = busy;
        n_waited = 0;
        if (ld_write) begin
          e_wa = ld_addr; e_wd = ld_wdata; e_ws = ld_wstrb;
        end else begin
          e_ra1 = ld_addr; n_resp = 1'b1; n_forced = busy; n_data = shadow[ld_addr];
        end
      end else begin
        n_waited = ld_valid ? ((m_waited < MW) ? m_waited + 1 : MW) : 0;
        if (cpu_we) e_ws = cpu_wstrb;
      end
    end
  endtask

  task automatic settle(string ctx);
    #1;
    model_eval();
    chk({ctx, ":ld_ready"},   32'(ld_ready),   32'(e_ready));
    chk({ctx, ":cpu_stall"},  32'(cpu_stall),  32'(e_stall));
    chk({ctx, ":ld_rvalid"},  32'(ld_rvalid),  32'(e_rvalid));
    chk({ctx, ":ld_rdata"},   ld_rdata,        e_rdata);
    chk({ctx, ":ram_raddr1"}, 32'(ram_raddr1), 32'(e_ra1));
    chk({ctx, ":ram_raddr2"}, 32'(ram_raddr2), 32'(e_ra2));
    chk({ctx, ":ram_wstrb"},  32'(ram_wstrb),  32'(e_ws));
    if (e_ws != 4'b0000) begin
      chk({ctx, ":ram_waddr"}, 32'(ram_waddr), 32'(e_wa));
      chk({ctx, ":ram_wdata"}, ram_wdata,      e_wd);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    m_waited      = n_waited;
    m_resp        = n_resp;
    m_resp_forced = n_forced;
    m_resp_data   = n_data;
    if (e_ws != 4'b0000) shadow[e_wa] = merge(shadow[e_wa], e_wd, e_ws);
    @(negedge CLK);
  endtask

  task automatic cpu_idle();
    cpu_re1 = 1'b0; cpu_re2 = 1'b0; cpu_we = 1'b0; cpu_wstrb = 4'b0000;
  endtask

  // Run until the expected grant cycle, checking ready is low before it.
  task automatic wait_grant(string ctx, int n);
    for (int k = 0; k <= n; k++) begin
      settle(ctx);
      chk({ctx, ":ready_at_cycle"}, 32'(ld_ready), 32'(k == n));
      tick();
    end
  endtask

  initial begin
    bit prev_hold, prev_stall;
    int dens;
    for (int a = 0; a < DEPTH; a++) shadow[a] = init_val(a);
    m_waited = 0; m_resp = 1'b0; m_resp_forced = 1'b0; m_resp_data = 32'h0;

    // Reset with both sides active: CPU addresses pass, nothing written.
    RST = 1'b1;
    cpu_re1 = 1'b1; cpu_re2 = 1'b1; cpu_raddr1 = 14'h5; cpu_raddr2 = 14'h7;
    cpu_we = 1'b1; cpu_waddr = 14'h9; cpu_wdata = 32'hCAFEF00D; cpu_wstrb = 4'hF;
    ld_valid = 1'b1; ld_write = 1'b0; ld_addr = 14'h3; ld_wdata = 32'h0; ld_wstrb = 4'h0;
    repeat (3) begin
      settle("reset");
      chk("reset:wstrb_zero", 32'(ram_wstrb), 32'h0);
      tick();
    end
    RST = 1'b0; ld_valid = 1'b0; cpu_idle();

    // Loader read with idle CPU: immediate grant, data next cycle.
    ld_valid = 1'b1; ld_write = 1'b0; ld_addr = 14'h10;
    settle("rd_idle");
    chk("rd_idle:ready", 32'(ld_ready), 32'h1);
    tick();
    ld_valid = 1'b0;
    settle("rd_idle_resp");
    chk("rd_idle:rdata", ld_rdata, 32'hDEADBEEF);
    chk("rd_idle:stall", 32'(cpu_stall), 32'h0);
    tick();

    // Partial-strobe loader write, then a CPU read of the same word.
    ld_valid = 1'b1; ld_write = 1'b1; ld_addr = 14'h20; ld_wdata = 32'h12345678; ld_wstrb = 4'b0011;
    settle("wr_idle");
    tick();
    ld_valid = 1'b0; cpu_re1 = 1'b1; cpu_raddr1 = 14'h20;
    settle("cpu_rd");
    tick();
    cpu_idle();
    settle("cpu_rd_data");
    chk("cpu_rd:0x20", ram_rdata1, 32'hAAAA5678);
    tick();

    // Continuous CPU reads: forced loader read after MAX_WAIT cycles.
    cpu_re1 = 1'b1; cpu_raddr1 = 14'h40;
    ld_valid = 1'b1; ld_write = 1'b0; ld_addr = 14'h10;
    for (int k = 0; k <= MW; k++) begin
      settle("forced_rd");
      chk("forced_rd:ready", 32'(ld_ready), 32'(k == MW));
      chk("forced_rd:stall", 32'(cpu_stall), 32'(k == MW));
      tick();
    end
    ld_valid = 1'b0;
    settle("forced_rd_resp");
    chk("forced_rd:rdata", ld_rdata, 32'hDEADBEEF);
    chk("forced_rd:resp_stall", 32'(cpu_stall), 32'h1);
    tick();
    cpu_idle();

    // CPU store collides with a forced loader write to the same word.
    cpu_we = 1'b1; cpu_waddr = 14'h30; cpu_wdata = 32'h11111111; cpu_wstrb = 4'hF;
    ld_valid = 1'b1; ld_write = 1'b1; ld_addr = 14'h30; ld_wdata = 32'h22222222; ld_wstrb = 4'hF;
    wait_grant("collide", MW);
    ld_valid = 1'b0;
    settle("collide_retry");
    chk("collide:loader_landed", ram[14'h30], 32'h22222222);
    tick();
    cpu_idle();
    settle("collide_after");
    chk("collide:final", ram[14'h30], 32'h11111111);
    tick();

    // Zero-strobe loader write: accepted, nothing written, no response.
    ld_valid = 1'b1; ld_write = 1'b1; ld_addr = 14'h30; ld_wdata = 32'h0; ld_wstrb = 4'h0;
    settle("wr_nostrb");
    tick();
    ld_valid = 1'b0;
    settle("wr_nostrb_after");
    chk("wr_nostrb:rvalid", 32'(ld_rvalid), 32'h0);
    tick();

    // Reset during the response cycle drops it and clears the wait.
    ld_valid = 1'b1; ld_write = 1'b0; ld_addr = 14'h10;
    settle("rst_resp_grant");
    tick();
    ld_valid = 1'b0; RST = 1'b1;
    settle("rst_resp");
    chk("rst_resp:rvalid", 32'(ld_rvalid), 32'h0);
    tick();
    RST = 1'b0;
    settle("rst_resp_after");
    chk("rst_resp_after:rvalid", 32'(ld_rvalid), 32'h0);
    tick();
    cpu_re1 = 1'b1; ld_valid = 1'b1;
    wait_grant("rst_resp_rewait", MW);
    ld_valid = 1'b0;
    settle("rst_resp_rewait_resp");
    tick();
    cpu_idle();

    // Loader gives up in PEND; a later request waits the full window again.
    cpu_re1 = 1'b1; ld_valid = 1'b1; ld_write = 1'b0; ld_addr = 14'h10;
    repeat (3) begin
      settle("drop_pend");
      tick();
    end
    ld_valid = 1'b0;
    settle("drop_pend_gone");
    chk("drop_pend:ready", 32'(ld_ready), 32'h0);
    tick();
    ld_valid = 1'b1;
    wait_grant("drop_rewait", MW);
    ld_valid = 1'b0;
    settle("drop_rewait_resp");
    tick();
    cpu_idle();

    // Constrained-random traffic with phases of varying CPU load.
    prev_hold = 1'b0; prev_stall = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      dens = (cyc / 80) % 4;
      RST = ($urandom_range(0, 99) == 0);
      if (!prev_stall) begin
        cpu_re1    = ($urandom_range(0, 3) < dens);
        cpu_re2    = ($urandom_range(0, 3) < dens);
        cpu_we     = ($urandom_range(0, 3) < dens);
        cpu_raddr1 = AW'($urandom_range(0, 15));
        cpu_raddr2 = AW'($urandom_range(0, 15));
        cpu_waddr  = AW'($urandom_range(0, 15));
        cpu_wdata  = $urandom;
        cpu_wstrb  = 4'($urandom_range(0, 15));
      end
      if (prev_hold) begin
        if ($urandom_range(0, 15) == 0) ld_valid = 1'b0;
      end else begin
        ld_valid = 1'($urandom_range(0, 1));
        ld_write = 1'($urandom_range(0, 1));
        ld_addr  = AW'($urandom_range(0, 15));
        ld_wdata = $urandom;
        ld_wstrb = 4'($urandom_range(0, 15));
      end
      settle("rnd");
      prev_hold  = ld_valid && !e_ready && !RST;
      prev_stall = e_stall;
      tick();
    end
    RST = 1'b0;

    // Final memory image must match the model's view everywhere touched.
    for (int a = 0; a < 64; a++) chk("mem_image", ram[a], shadow[a]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
